// File: rtl/dcache_arb_pkg.sv
// Shared types and constants for the multi-port D-cache arbiter.
// FSM state encoding and grant-policy selectors.
package dcache_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RECOVER = 2'd2
    } arb_state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    localparam int unsigned WAIT_CNT_W = 8;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotating find-first: picks the first set request bit
// at or after i_base, wrapping modulo N.
module rr_priority_picker #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_base,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    localparam logic [IDX_W:0] NUM = (IDX_W + 1)'(N);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_sum   = '0;
        w_cand  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_sum = {1'b0, i_base} + (IDX_W + 1)'(k);
            // two wraps cover any base up to 2**IDX_W-1 for non-power-of-two N
            if (w_sum >= NUM) w_sum = w_sum - NUM;
            if (w_sum >= NUM) w_sum = w_sum - NUM;
            w_cand = w_sum[IDX_W-1:0];
            if (!o_valid && i_req[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/dcache_multiport_arbiter.sv
// Arbitrates NUM_PORTS requesters onto a single D-cache port with
// fixed-priority or round-robin grants plus starvation escalation.
module dcache_multiport_arbiter
    import dcache_arb_pkg::*;
#(
    parameter int NUM_PORTS    = 3,
    parameter int ADDR_W       = 19,
    parameter int DATA_W       = 16,
    parameter int ARB_MODE     = ARB_FIXED,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS*ADDR_W-1:0]     req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]     req_wdata,
    input  logic [NUM_PORTS-1:0]            req_access,
    input  logic [NUM_PORTS-1:0]            req_wr_en,
    input  logic [NUM_PORTS*DATA_W/8-1:0]   req_bytesel,
    output logic [NUM_PORTS*DATA_W-1:0]     req_rdata,
    output logic [NUM_PORTS-1:0]            req_ack,
    output logic [ADDR_W-1:0]               cache_addr,
    output logic [DATA_W-1:0]               cache_wdata,
    output logic                            cache_access,
    output logic                            cache_wr_en,
    output logic [DATA_W/8-1:0]             cache_bytesel,
    input  logic [DATA_W-1:0]               cache_rdata,
    input  logic                            cache_ack,
    output logic [$clog2(NUM_PORTS)-1:0]    grant_id,
    output logic                            busy
);

    localparam int unsigned GW = $clog2(NUM_PORTS);
    localparam int unsigned BW = DATA_W / 8;
    localparam logic [GW-1:0] LAST_IDX = GW'(NUM_PORTS - 1);
    localparam logic [WAIT_CNT_W-1:0] LIMIT = WAIT_CNT_W'(STARVE_LIMIT);

    logic [NUM_PORTS-1:0][ADDR_W-1:0] w_addr_v;
    logic [NUM_PORTS-1:0][DATA_W-1:0] w_wdata_v;
    logic [NUM_PORTS-1:0][BW-1:0]     w_bsel_v;

    arb_state_t                            r_state;
    logic [GW-1:0]                         r_grant;
    logic [GW-1:0]                         r_last;
    logic                                  r_busy;
    logic [NUM_PORTS-1:0]                  r_ack;
    logic [NUM_PORTS-1:0][DATA_W-1:0]      r_rdata;
    logic [NUM_PORTS-1:0][WAIT_CNT_W-1:0]  r_wait;

    logic [NUM_PORTS-1:0] w_urgent;
    logic [GW-1:0]        w_base;
    logic [GW-1:0]        w_urg_idx;
    logic [GW-1:0]        w_norm_idx;
    logic [GW-1:0]        w_win;
    logic                 w_urg_valid;
    logic                 w_norm_valid;
    logic                 w_gnt_req;

    assign w_addr_v  = req_addr;
    assign w_wdata_v = req_wdata;
    assign w_bsel_v  = req_bytesel;

    always_comb begin
        w_urgent = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            w_urgent[i] = req_access[i] && (r_wait[i] == LIMIT);
        end
    end

    assign w_base = (ARB_MODE == ARB_RR) ?
                    ((r_last == LAST_IDX) ? '0 : r_last + 1'b1) : '0;

    rr_priority_picker #(
        .N     (NUM_PORTS),
        .IDX_W (GW)
    ) u_pick_urgent (
        .i_req   (w_urgent),
        .i_base  ('0),
        .o_valid (w_urg_valid),
        .o_idx   (w_urg_idx)
    );

    rr_priority_picker #(
        .N     (NUM_PORTS),
        .IDX_W (GW)
    ) u_pick_normal (
        .i_req   (req_access),
        .i_base  (w_base),
        .o_valid (w_norm_valid),
        .o_idx   (w_norm_idx)
    );

    // starving ports override the configured policy, lowest index first
    assign w_win     = w_urg_valid ? w_urg_idx : w_norm_idx;
    assign w_gnt_req = req_access[r_grant];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_last  <= LAST_IDX;
            r_busy  <= 1'b0;
            r_ack   <= '0;
            r_rdata <= '0;
            r_wait  <= '0;
        end else begin
            r_ack <= '0;
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (!req_access[i]) r_wait[i] <= '0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_norm_valid) begin
                        r_grant <= w_win;
                        r_busy  <= 1'b1;
                        r_state <= ST_GRANT;
                        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                            if (req_access[i]) begin
                                if (GW'(i) == w_win)
                                    r_wait[i] <= '0;
                                else if (r_wait[i] != LIMIT)
                                    r_wait[i] <= r_wait[i] + 1'b1;
                            end
                        end
                    end
                end
                ST_GRANT: begin
                    if (cache_ack) begin
                        r_rdata[r_grant] <= cache_rdata;
                        r_ack[r_grant]   <= 1'b1;
                        r_last           <= r_grant;
                        r_state          <= ST_RECOVER;
                    end else if (!w_gnt_req) begin
                        r_state <= ST_RECOVER;
                    end
                end
                ST_RECOVER: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // cache side is combinational so an async reset drops access immediately
    always_comb begin
        cache_access  = 1'b0;
        cache_addr    = '0;
        cache_wdata   = '0;
        cache_wr_en   = 1'b0;
        cache_bytesel = '1;
        if (r_state == ST_GRANT) begin
            cache_access  = w_gnt_req;
            cache_addr    = w_addr_v[r_grant];
            cache_wdata   = w_wdata_v[r_grant];
            cache_wr_en   = req_wr_en[r_grant];
            cache_bytesel = w_bsel_v[r_grant];
        end
    end

    assign req_rdata = r_rdata;
    assign req_ack   = r_ack;
    assign grant_id  = r_grant;
    assign busy      = r_busy;

endmodule

// File: tb/tb_dcache_multiport_arbiter.sv
// Self-checking bench for dcache_multiport_arbiter: default, round-robin
// and starvation-limited instances driven from one scenario sequence.
module tb_dcache_multiport_arbiter;
    localparam int NP = 3;
    localparam int AW = 19;
    localparam int DW = 16;
    localparam int BW = 2;

    typedef struct {
        int            port;
        logic [DW-1:0] data;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [NP*AW-1:0] req_addr    = '0;
    logic [NP*DW-1:0] req_wdata   = '0;
    logic [NP-1:0]    req_access  = '0;
    logic [NP-1:0]    req_wr_en   = '0;
    logic [NP*BW-1:0] req_bytesel = '0;
    logic [NP*DW-1:0] req_rdata;
    logic [NP-1:0]    req_ack;
    logic [AW-1:0]    cache_addr;
    logic [DW-1:0]    cache_wdata;
    logic             cache_access;
    logic             cache_wr_en;
    logic [BW-1:0]    cache_bytesel;
    logic [DW-1:0]    cache_rdata;
    logic             cache_ack;
    logic [1:0]       grant_id;
    logic             busy;

    logic             resp_en  = 1'b1;
    logic             man_ack  = 1'b0;
    logic [DW-1:0]    man_data = '0;
    logic             auto_ack = 1'b0;
    logic [DW-1:0]    auto_data = '0;
    int               lat = 0;

    assign cache_ack   = resp_en ? auto_ack  : man_ack;
    assign cache_rdata = resp_en ? auto_data : man_data;

    logic [NP-1:0]    rr_req_access = '0;
    logic [NP*DW-1:0] rr_req_rdata;
    logic [NP-1:0]    rr_req_ack;
    logic [AW-1:0]    rr_cache_addr;
    logic [DW-1:0]    rr_cache_wdata;
    logic             rr_cache_access;
    logic             rr_cache_wr_en;
    logic [BW-1:0]    rr_cache_bytesel;
    logic             rr_cache_ack = 1'b0;
    logic [1:0]       rr_grant_id;
    logic             rr_busy;

    logic [NP-1:0]    st_req_access = '0;
    logic [NP*DW-1:0] st_req_rdata;
    logic [NP-1:0]    st_req_ack;
    logic [AW-1:0]    st_cache_addr;
    logic [DW-1:0]    st_cache_wdata;
    logic             st_cache_access;
    logic             st_cache_wr_en;
    logic [BW-1:0]    st_cache_bytesel;
    logic             st_cache_ack = 1'b0;
    logic [1:0]       st_grant_id;
    logic             st_busy;

    int pass_cnt  = 0;
    int total_cnt = 0;
    exp_t          sb[$];
    logic [DW-1:0] exp_rd [NP];

    dcache_multiport_arbiter dut (
        .clk(clk), .reset(reset),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_access(req_access),
        .req_wr_en(req_wr_en), .req_bytesel(req_bytesel),
        .req_rdata(req_rdata), .req_ack(req_ack),
        .cache_addr(cache_addr), .cache_wdata(cache_wdata), .cache_access(cache_access),
        .cache_wr_en(cache_wr_en), .cache_bytesel(cache_bytesel),
        .cache_rdata(cache_rdata), .cache_ack(cache_ack),
        .grant_id(grant_id), .busy(busy)
    );

    dcache_multiport_arbiter #(.ARB_MODE(dcache_arb_pkg::ARB_RR)) dut_rr (
        .clk(clk), .reset(reset),
        .req_addr('0), .req_wdata('0), .req_access(rr_req_access),
        .req_wr_en('0), .req_bytesel('1),
        .req_rdata(rr_req_rdata), .req_ack(rr_req_ack),
        .cache_addr(rr_cache_addr), .cache_wdata(rr_cache_wdata), .cache_access(rr_cache_access),
        .cache_wr_en(rr_cache_wr_en), .cache_bytesel(rr_cache_bytesel),
        .cache_rdata(16'h0000), .cache_ack(rr_cache_ack),
        .grant_id(rr_grant_id), .busy(rr_busy)
    );

    dcache_multiport_arbiter #(.STARVE_LIMIT(2)) dut_st (
        .clk(clk), .reset(reset),
        .req_addr('0), .req_wdata('0), .req_access(st_req_access),
        .req_wr_en('0), .req_bytesel('1),
        .req_rdata(st_req_rdata), .req_ack(st_req_ack),
        .cache_addr(st_cache_addr), .cache_wdata(st_cache_wdata), .cache_access(st_cache_access),
        .cache_wr_en(st_cache_wr_en), .cache_bytesel(st_cache_bytesel),
        .cache_rdata(16'h0000), .cache_ack(st_cache_ack),
        .grant_id(st_grant_id), .busy(st_busy)
    );

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        if (a == 19'h01234) return 16'hBEEF;
        return a[15:0] ^ 16'hA5C3;
    endfunction

    function automatic int ack_port(input logic [NP-1:0] v);
        for (int i = 0; i < NP; i++) if (v[i]) return i;
        return -1;
    endfunction

    // cache model: ack two cycles after access is first seen
    always @(negedge clk) begin
        if (cache_access && !auto_ack) begin
            if (lat == 2) begin
                auto_ack  = 1'b1;
                auto_data = mem_fn(cache_addr);
                lat       = 0;
            end else begin
                lat = lat + 1;
            end
        end else begin
            auto_ack = 1'b0;
            lat      = 0;
        end
        rr_cache_ack = rr_cache_access && !rr_cache_ack;
        st_cache_ack = st_cache_access && !st_cache_ack;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic [AW-1:0] a, input logic we,
                           input logic [DW-1:0] wd, input logic [BW-1:0] bs);
        req_addr[p*AW +: AW]    = a;
        req_wdata[p*DW +: DW]   = wd;
        req_bytesel[p*BW +: BW] = bs;
        req_wr_en[p]            = we;
        req_access[p]           = 1'b1;
    endtask

    task automatic push_exp(input int p, input logic [DW-1:0] d);
        exp_t e;
        e.port = p;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic wait_ack(input int max_t, output int p);
        p = -1;
        for (int t = 0; t < max_t; t++) begin
            tick();
            if (req_ack != '0) begin
                p = ack_port(req_ack);
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (grant_id !== 2'd0) $display("FAIL rst_grant: got %0d want 0", grant_id); else pass_cnt++;
        total_cnt++; if (req_ack !== 3'b000) $display("FAIL rst_ack: got %b want 000", req_ack); else pass_cnt++;
        total_cnt++; if (req_rdata !== 48'h0) $display("FAIL rst_rdata: got %h want 0", req_rdata); else pass_cnt++;
        total_cnt++; if (cache_access !== 1'b0) $display("FAIL rst_access: got %b want 0", cache_access); else pass_cnt++;
        total_cnt++; if (cache_bytesel !== 2'b11) $display("FAIL rst_bytesel: got %b want 11", cache_bytesel); else pass_cnt++;
        total_cnt++; if (cache_addr !== 19'h0) $display("FAIL rst_addr: got %h want 0", cache_addr); else pass_cnt++;
        reset = 1'b0;
        foreach (exp_rd[i]) exp_rd[i] = '0;
        tick();
    endtask

    task automatic test_fixed_two_ports();
        int t_ack0 = -1, t_g2 = -1, t_rack0 = -1, n = 0, p;
        exp_t e;
        resp_en = 1'b1;
        set_req(0, 19'h00100, 1'b0, 16'h0, 2'b11);
        set_req(2, 19'h00200, 1'b0, 16'h0, 2'b11);
        push_exp(0, mem_fn(19'h00100));
        push_exp(2, mem_fn(19'h00200));
        for (int t = 0; t < 60 && n < 2; t++) begin
            tick();
            if (cache_ack && cache_access && grant_id == 2'd0 && t_ack0 < 0) t_ack0 = t;
            if (cache_access && grant_id == 2'd2 && t_g2 < 0) t_g2 = t;
            if (req_ack != '0) begin
                p = ack_port(req_ack);
                if (req_ack[0] && t_rack0 < 0) t_rack0 = t;
                total_cnt++; if (!$onehot(req_ack)) $display("FAIL two_onehot: got %b want one-hot", req_ack); else pass_cnt++;
                if (sb.size() == 0) begin
                    total_cnt++; $display("FAIL two_sb: got unexpected ack on port %0d want none", p);
                end else begin
                    e = sb.pop_front();
                    total_cnt++; if (p !== e.port) $display("FAIL two_order: got port %0d want %0d", p, e.port); else pass_cnt++;
                    total_cnt++; if (req_rdata[e.port*DW +: DW] !== e.data)
                        $display("FAIL two_rdata: got %h want %h", req_rdata[e.port*DW +: DW], e.data); else pass_cnt++;
                    exp_rd[e.port] = e.data;
                end
                req_access[p] = 1'b0;
                n++;
            end
        end
        req_access = '0;
        total_cnt++; if (n !== 2) $display("FAIL two_timeout: got %0d acks want 2", n); else pass_cnt++;
        total_cnt++; if (t_rack0 - t_ack0 !== 1) $display("FAIL two_ack_lat: got %0d want 1", t_rack0 - t_ack0); else pass_cnt++;
        total_cnt++; if (t_g2 - t_ack0 !== 3) $display("FAIL two_spacing: got %0d want 3", t_g2 - t_ack0); else pass_cnt++;
        tick();
    endtask

    task automatic test_write_mux();
        int p;
        exp_t e;
        resp_en = 1'b1;
        set_req(1, 19'h00ABC, 1'b1, 16'h5A5A, 2'b10);
        push_exp(1, mem_fn(19'h00ABC));
        tick();
        total_cnt++; if (cache_access !== 1'b1) $display("FAIL wr_access: got %b want 1", cache_access); else pass_cnt++;
        total_cnt++; if (grant_id !== 2'd1) $display("FAIL wr_grant: got %0d want 1", grant_id); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL wr_busy: got %b want 1", busy); else pass_cnt++;
        total_cnt++; if (cache_addr !== 19'h00ABC) $display("FAIL wr_addr: got %h want 00abc", cache_addr); else pass_cnt++;
        total_cnt++; if (cache_wdata !== 16'h5A5A) $display("FAIL wr_wdata: got %h want 5a5a", cache_wdata); else pass_cnt++;
        total_cnt++; if (cache_wr_en !== 1'b1) $display("FAIL wr_en: got %b want 1", cache_wr_en); else pass_cnt++;
        total_cnt++; if (cache_bytesel !== 2'b10) $display("FAIL wr_bytesel: got %b want 10", cache_bytesel); else pass_cnt++;
        wait_ack(20, p);
        total_cnt++; if (p !== 1) $display("FAIL wr_ack: got port %0d want 1", p); else pass_cnt++;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            total_cnt++; if (req_rdata[DW +: DW] !== e.data) $display("FAIL wr_rdata: got %h want %h", req_rdata[DW +: DW], e.data); else pass_cnt++;
            exp_rd[1] = e.data;
        end
        // port 1 still holds its request during RECOVER; cache side must be idle
        total_cnt++; if (cache_access !== 1'b0) $display("FAIL rec_access: got %b want 0", cache_access); else pass_cnt++;
        total_cnt++; if (cache_addr !== 19'h0) $display("FAIL rec_addr: got %h want 0", cache_addr); else pass_cnt++;
        total_cnt++; if (cache_wdata !== 16'h0) $display("FAIL rec_wdata: got %h want 0", cache_wdata); else pass_cnt++;
        total_cnt++; if (cache_wr_en !== 1'b0) $display("FAIL rec_wr_en: got %b want 0", cache_wr_en); else pass_cnt++;
        total_cnt++; if (cache_bytesel !== 2'b11) $display("FAIL rec_bytesel: got %b want 11", cache_bytesel); else pass_cnt++;
        req_access[1] = 1'b0;
        req_wr_en[1]  = 1'b0;
        tick();
    endtask

    task automatic test_read_port1();
        int p;
        exp_t e;
        resp_en = 1'b1;
        set_req(1, 19'h01234, 1'b0, 16'h0, 2'b11);
        push_exp(1, 16'hBEEF);
        wait_ack(20, p);
        total_cnt++; if (req_ack !== 3'b010) $display("FAIL rd_ack: got %b want 010", req_ack); else pass_cnt++;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            total_cnt++; if (req_rdata[DW +: DW] !== e.data) $display("FAIL rd_rdata: got %h want %h", req_rdata[DW +: DW], e.data); else pass_cnt++;
            exp_rd[1] = e.data;
        end
        total_cnt++; if (req_rdata[0 +: DW] !== exp_rd[0]) $display("FAIL rd_hold0: got %h want %h", req_rdata[0 +: DW], exp_rd[0]); else pass_cnt++;
        total_cnt++; if (req_rdata[2*DW +: DW] !== exp_rd[2]) $display("FAIL rd_hold2: got %h want %h", req_rdata[2*DW +: DW], exp_rd[2]); else pass_cnt++;
        req_access[1] = 1'b0;
        tick();
        total_cnt++; if (req_ack !== 3'b000) $display("FAIL rd_pulse: got %b want 000", req_ack); else pass_cnt++;
        total_cnt++; if (req_rdata[DW +: DW] !== 16'hBEEF) $display("FAIL rd_keep: got %h want beef", req_rdata[DW +: DW]); else pass_cnt++;
        if (p < 0) begin
            total_cnt++; $display("FAIL rd_timeout: got no ack want port 1");
        end
    endtask

    task automatic test_abort();
        resp_en = 1'b0;
        man_ack = 1'b0;
        set_req(0, 19'h00333, 1'b0, 16'h0, 2'b11);
        tick();
        total_cnt++; if (cache_access !== 1'b1) $display("FAIL ab_access: got %b want 1", cache_access); else pass_cnt++;
        req_access[0] = 1'b0;
        #1;
        total_cnt++; if (cache_access !== 1'b0) $display("FAIL ab_drop: got %b want 0", cache_access); else pass_cnt++;
        tick();
        total_cnt++; if (busy !== 1'b1) $display("FAIL ab_recover: got %b want 1", busy); else pass_cnt++;
        total_cnt++; if (req_ack !== 3'b000) $display("FAIL ab_noack: got %b want 000", req_ack); else pass_cnt++;
        man_ack  = 1'b1;
        man_data = 16'hDEAD;
        tick();
        man_ack = 1'b0;
        total_cnt++; if (busy !== 1'b0) $display("FAIL ab_idle: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (req_ack !== 3'b000) $display("FAIL ab_late: got %b want 000", req_ack); else pass_cnt++;
        total_cnt++; if (req_rdata[0 +: DW] !== exp_rd[0]) $display("FAIL ab_rdata: got %h want %h", req_rdata[0 +: DW], exp_rd[0]); else pass_cnt++;
        tick();
        total_cnt++; if (req_ack !== 3'b000) $display("FAIL ab_after: got %b want 000", req_ack); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL ab_stay: got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_reset_mid_grant();
        int p;
        exp_t e;
        resp_en = 1'b0;
        man_ack = 1'b0;
        set_req(2, 19'h00777, 1'b0, 16'h0, 2'b11);
        tick();
        total_cnt++; if (cache_access !== 1'b1) $display("FAIL mr_pre: got %b want 1", cache_access); else pass_cnt++;
        reset = 1'b1;
        #1;
        total_cnt++; if (cache_access !== 1'b0) $display("FAIL mr_access: got %b want 0", cache_access); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL mr_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (grant_id !== 2'd0) $display("FAIL mr_grant: got %0d want 0", grant_id); else pass_cnt++;
        total_cnt++; if (req_rdata !== 48'h0) $display("FAIL mr_rdata: got %h want 0", req_rdata); else pass_cnt++;
        total_cnt++; if (cache_bytesel !== 2'b11) $display("FAIL mr_bytesel: got %b want 11", cache_bytesel); else pass_cnt++;
        tick();
        total_cnt++; if (req_ack !== 3'b000) $display("FAIL mr_ack: got %b want 000", req_ack); else pass_cnt++;
        reset = 1'b0;
        foreach (exp_rd[i]) exp_rd[i] = '0;
        resp_en = 1'b1;
        push_exp(2, mem_fn(19'h00777));
        wait_ack(30, p);
        total_cnt++; if (p !== 2) $display("FAIL mr_serve: got port %0d want 2", p); else pass_cnt++;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            total_cnt++; if (req_rdata[2*DW +: DW] !== e.data) $display("FAIL mr_data: got %h want %h", req_rdata[2*DW +: DW], e.data); else pass_cnt++;
            exp_rd[2] = e.data;
        end
        req_access[2] = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        int exp_q[$];
        int n = 0, p, e;
        exp_q = '{0, 1, 2, 0, 1, 2};
        rr_req_access = 3'b111;
        for (int t = 0; t < 200 && n < 6; t++) begin
            tick();
            if (rr_req_ack != '0) begin
                p = ack_port(rr_req_ack);
                e = exp_q.pop_front();
                total_cnt++; if (p !== e) $display("FAIL rr_order%0d: got port %0d want %0d", n, p, e); else pass_cnt++;
                n++;
            end
        end
        rr_req_access = '0;
        total_cnt++; if (n !== 6) $display("FAIL rr_timeout: got %0d acks want 6", n); else pass_cnt++;
        repeat (2) tick();
    endtask

    task automatic test_starvation();
        int exp_q[$];
        int n = 0, p, e;
        exp_q = '{0, 0, 2};
        st_req_access = 3'b101;
        for (int t = 0; t < 200 && n < 3; t++) begin
            tick();
            if (st_req_ack != '0) begin
                p = ack_port(st_req_ack);
                e = exp_q.pop_front();
                total_cnt++; if (p !== e) $display("FAIL st_order%0d: got port %0d want %0d", n, p, e); else pass_cnt++;
                n++;
            end
        end
        st_req_access = '0;
        total_cnt++; if (n !== 3) $display("FAIL st_timeout: got %0d acks want 3", n); else pass_cnt++;
        repeat (2) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fixed_two_ports();
        test_write_mux();
        test_read_port1();
        test_abort();
        test_reset_mid_grant();
        test_round_robin();
        test_starvation();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/dcache_multiport_arbiter.md
DCACHE_MULTIPORT_ARBITER -- requirements
Module: dcache_multiport_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 3, number of requester ports (2..8); port 0 is highest fixed priority.
REQ-002 SHALL have parameter ADDR_W, default 19, word-address width (bits [ADDR_W:1] of byte address).
REQ-003 SHALL have parameter DATA_W, default 16, data width; bytesel width = DATA_W/8.
REQ-004 SHALL have parameter ARB_MODE, default 0, grant policy: 0 = fixed priority, 1 = round-robin.
REQ-005 SHALL have parameter STARVE_LIMIT, default 15, lost arbitrations before a port becomes urgent (1..255).
REQ-006 SHALL have ports, clock and reset first:
  clk  in  1  clock
  reset  in  1  asynchronous, active-high reset
  req_addr  in  NUM_PORTS*ADDR_W  per-port address, port i at slice i
  req_wdata  in  NUM_PORTS*DATA_W  per-port write data
  req_access  in  NUM_PORTS  per-port request, held until req_ack
  req_wr_en  in  NUM_PORTS  per-port write enable
  req_bytesel  in  NUM_PORTS*DATA_W/8  per-port byte select
  req_rdata  out  NUM_PORTS*DATA_W  per-port registered read data
  req_ack  out  NUM_PORTS  per-port registered one-cycle ack
  cache_addr  out  ADDR_W  to D-cache
  cache_wdata  out  DATA_W  to D-cache
  cache_access  out  1  to D-cache
  cache_wr_en  out  1  to D-cache
  cache_bytesel  out  DATA_W/8  to D-cache
  cache_rdata  in  DATA_W  from D-cache
  cache_ack  in  1  from D-cache
  grant_id  out  clog2(NUM_PORTS)  index of port currently granted
  busy  out  1  FSM not IDLE

Function
REQ-007 SHALL implement FSM states IDLE, GRANT, RECOVER.
REQ-008 IDLE: if any req_access, SHALL latch winner into grant_id and enter GRANT next cycle; else stay.
REQ-009 Winner SHALL be lowest-index urgent requester if any exists; else per ARB_MODE.
REQ-010 ARB_MODE 0: lowest-index requester wins.
REQ-011 ARB_MODE 1: first requester at or after (last_grant+1) mod NUM_PORTS wins, wrapping; last_grant resets to NUM_PORTS-1.
REQ-012 GRANT: cache_addr/wdata/wr_en/bytesel SHALL mux the granted port; cache_access = req_access[grant_id].
REQ-013 Outside GRANT: cache_access=0, cache_addr=0, cache_wdata=0, cache_wr_en=0, cache_bytesel=all ones.
REQ-014 GRANT with cache_ack: SHALL capture cache_rdata into req_rdata[grant_id], pulse req_ack[grant_id] the next cycle, update last_grant, enter RECOVER.
REQ-015 GRANT with req_access[grant_id] low and no cache_ack (abort): SHALL enter RECOVER with no req_ack and no rdata update.
REQ-016 RECOVER SHALL last exactly one cycle, ignore cache_ack and requests, then enter IDLE.
REQ-017 Latency: request to cache_access = 1 cycle; cache_ack to req_ack = 1 cycle; back-to-back grants spaced by 3 cycles minimum.
REQ-018 Each port SHALL have a wait counter: +1 (saturating at STARVE_LIMIT) when it requests in IDLE and loses; cleared on grant or when its req_access is low; urgent when equal to STARVE_LIMIT.
REQ-019 At most one req_ack bit SHALL be high per cycle; req_rdata of non-acked ports SHALL hold.
REQ-020 busy SHALL be 1 in GRANT and RECOVER.

Reset
REQ-021 reset SHALL force IDLE, grant_id=0, last_grant=NUM_PORTS-1, all wait counters 0, req_ack=0, req_rdata=0, cache outputs per REQ-013.
REQ-022 Reset asserted mid-GRANT SHALL drop cache_access in the same cycle (asynchronous) and issue no req_ack.

Structure
REQ-023 State enum and ARB_MODE constants (ARB_FIXED=0, ARB_RR=1) SHALL live in shared package dcache_arb_pkg.
REQ-024 Rotating find-first selection SHALL be a combinational sub-module rr_priority_picker (inputs request vector, base index; outputs valid, index).

Verification
REQ-025 Defaults, ARB_MODE 0, ports 0 and 2 request together, cache_ack 2 cycles after cache_access -> port 0 acked first, port 2 granted 3 cycles after port 0's cache_ack.
REQ-026 ARB_MODE 1, all 3 ports request continuously -> grant order 0,1,2,0,1,2.
REQ-027 ARB_MODE 0, STARVE_LIMIT 2, port 0 re-requests continuously, port 2 holds request -> port 2 granted on its third IDLE arbitration.
REQ-028 Port 1 read at addr 0x1234, cache_rdata 0xBEEF -> req_rdata[1]=0xBEEF with req_ack[1] high one cycle; other req_rdata unchanged.
REQ-029 Granted port drops req_access before cache_ack -> no req_ack, RECOVER then IDLE; late cache_ack in RECOVER ignored.
REQ-030 reset asserted during GRANT -> cache_access 0 immediately, all outputs at reset values, next request served normally.
